// File: rtl/mygpio_pwm_pkg.sv
// Shared definitions for the mygpio PWM H-bridge drive: control-register bit map,
// channel state encoding and the state-to-pin mapping used by both channels.
package mygpio_pwm_pkg;

    localparam int CTRL_W      = 5;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_DIR_A  = 1;
    localparam int CTRL_DIR_B  = 2;
    localparam int CTRL_BRAKE  = 3;
    localparam int CTRL_IRQ_EN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2,
        ST_BRAKE = 2'd3
    } chan_state_t;

    // Returns {pwm, in1, in2}; only DRIVE lets the duty compare reach the bridge.
    function automatic logic [2:0] drive_pins(chan_state_t st, logic dir, logic raw);
        logic [2:0] p;
        p = 3'b000;
        case (st)
            ST_DRIVE: p = {raw, dir, ~dir};
            ST_BRAKE: p = 3'b111;
            default:  p = 3'b000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mygpio_pwm_chan.sv
// One H-bridge channel: registered duty compare, IDLE/DRIVE/DEAD/BRAKE state machine
// and the dead-time counter that separates every direction reversal.
module mygpio_pwm_chan
    import mygpio_pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DEADTIME = 50
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             en_i,
    input  logic             brake_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
    output logic             in1_o,
    output logic             in2_o
);

    localparam int            TW      = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [TW-1:0] DT_LAST = TW'(DEADTIME - 1);

    chan_state_t   state_q, state_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] dt_q, dt_d;
    logic          raw_q;

    // In DEAD, dir_q tracks the requested direction so a second flip restarts the timer.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dt_d    = dt_q;
        case (state_q)
            ST_IDLE: begin
                dt_d = '0;
                if (en_i) begin
                    if (brake_i) begin
                        state_d = ST_BRAKE;
                    end else begin
                        state_d = ST_DRIVE;
                        dir_d   = dir_i;
                    end
                end
            end
            ST_DRIVE: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (brake_i) begin
                    state_d = ST_BRAKE;
                end else if (dir_i != dir_q) begin
                    state_d = ST_DEAD;
                    dir_d   = dir_i;
                    dt_d    = '0;
                end
            end
            ST_DEAD: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    dt_d    = '0;
                end else if (dir_i != dir_q) begin
                    dir_d = dir_i;
                    dt_d  = '0;
                end else if (dt_q == DT_LAST) begin
                    state_d = ST_DRIVE;
                    dt_d    = '0;
                end else begin
                    dt_d = dt_q + 1'b1;
                end
            end
            ST_BRAKE: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (!brake_i) begin
                    state_d = ST_DEAD;
                    dir_d   = dir_i;
                    dt_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            dt_q    <= '0;
            raw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dt_q    <= dt_d;
            raw_q   <= (cnt_i < duty_i);
        end
    end

    assign {pwm_o, in1_o, in2_o} = drive_pins(state_q, dir_q, raw_q);

endmodule

// File: rtl/mygpio_pwm_drive.sv
// Two-channel H-bridge PWM drive fed from mygpio slave regs 0..3: pending/shadow config,
// shared period counter, per-channel drive. Period IRQ only when MYGPIO_PWM_IRQ_EN is defined.
module mygpio_pwm_drive
    import mygpio_pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DEADTIME = 50
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty_a,
    input  logic [CNT_W-1:0] cfg_duty_b,
    input  logic [7:0]       cfg_ctrl,
    input  logic             irq_ack,
    output logic             pwm_a,
    output logic             pwm_b,
    output logic             in1_a,
    output logic             in2_a,
    output logic             in1_b,
    output logic             in2_b,
    output logic             period_tick,
    output logic             cfg_pending,
    output logic             irq
);

    logic [CNT_W-1:0]            pend_per_q, per_s_q;
    logic [1:0][CNT_W-1:0]       pend_duty_q, duty_s_q;
    logic [CTRL_W-1:0]           pend_ctrl_q, ctrl_s_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        pending_q, pending_d;
    logic                        en_s, wrap, apply;
    logic [1:0]                  pwm, in1, in2;
    logic                        unused_rsvd;

    assign unused_rsvd = ^cfg_ctrl[7:CTRL_W];

    assign en_s  = ctrl_s_q[CTRL_EN];
    assign wrap  = en_s && (per_s_q != '0) && (cnt_q == per_s_q);
    // Config only swaps at a period boundary, or at once while the bridge is disabled.
    assign apply = wrap || !en_s;

    assign cnt_d     = (!en_s || (per_s_q == '0) || wrap) ? '0 : cnt_q + 1'b1;
    assign pending_d = cfg_wr ? 1'b1 : (apply ? 1'b0 : pending_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pend_per_q  <= '0;
            pend_duty_q <= '0;
            pend_ctrl_q <= '0;
            per_s_q     <= '0;
            duty_s_q    <= '0;
            ctrl_s_q    <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            if (apply) begin
                per_s_q  <= pend_per_q;
                duty_s_q <= pend_duty_q;
                ctrl_s_q <= pend_ctrl_q;
            end
            if (cfg_wr) begin
                pend_per_q  <= cfg_period;
                pend_duty_q <= {cfg_duty_b, cfg_duty_a};
                pend_ctrl_q <= cfg_ctrl[CTRL_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_chan
        mygpio_pwm_chan #(
            .CNT_W   (CNT_W),
            .DEADTIME(DEADTIME)
        ) u_chan (
            .ACLK   (ACLK),
            .ARESET (ARESET),
            .en_i   (en_s),
            .brake_i(ctrl_s_q[CTRL_BRAKE]),
            .dir_i  (ctrl_s_q[CTRL_DIR_A + g]),
            .cnt_i  (cnt_q),
            .duty_i (duty_s_q[g]),
            .pwm_o  (pwm[g]),
            .in1_o  (in1[g]),
            .in2_o  (in2[g])
        );
    end

`ifdef MYGPIO_PWM_IRQ_EN
    logic irq_q, irq_d;

    // Acknowledge beats a set arriving in the same cycle.
    assign irq_d = irq_ack ? 1'b0 : ((wrap && ctrl_s_q[CTRL_IRQ_EN]) ? 1'b1 : irq_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq;

    assign unused_irq = irq_ack ^ ctrl_s_q[CTRL_IRQ_EN];
    assign irq        = 1'b0;
`endif

    assign pwm_a       = pwm[0];
    assign in1_a       = in1[0];
    assign in2_a       = in2[0];
    assign pwm_b       = pwm[1];
    assign in1_b       = in1[1];
    assign in2_b       = in2[1];
    assign period_tick = wrap;
    assign cfg_pending = pending_q;

endmodule

// File: tb/tb_mygpio_pwm_drive.sv
// Directed bench for mygpio_pwm_drive: behavioural reference checked every cycle,
// plus hand-computed window counts (duty, tick spacing, dead time, brake, irq).
module tb_mygpio_pwm_drive;

    localparam int CNT_W    = 16;
    localparam int DEADTIME = 50;
`ifdef MYGPIO_PWM_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam int OFF = 0, DRV = 1, DEADM = 2, BRK = 3;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic             cfg_wr = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_duty_a = '0;
    logic [CNT_W-1:0] cfg_duty_b = '0;
    logic [7:0]       cfg_ctrl = '0;
    logic             irq_ack = 1'b0;
    logic pwm_a, pwm_b, in1_a, in2_a, in1_b, in2_b, period_tick, cfg_pending, irq;

    always #5 ACLK = ~ACLK;

    mygpio_pwm_drive #(.CNT_W(CNT_W), .DEADTIME(DEADTIME)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_wr(cfg_wr), .cfg_period(cfg_period),
        .cfg_duty_a(cfg_duty_a), .cfg_duty_b(cfg_duty_b), .cfg_ctrl(cfg_ctrl),
        .irq_ack(irq_ack), .pwm_a(pwm_a), .pwm_b(pwm_b), .in1_a(in1_a), .in2_a(in2_a),
        .in1_b(in1_b), .in2_b(in2_b), .period_tick(period_tick),
        .cfg_pending(cfg_pending), .irq(irq)
    );

    // Reference model state: plain integers describing what the spec says is held.
    int m_pend_per = 0, m_pend_da = 0, m_pend_db = 0, m_pend_ctrl = 0;
    bit m_pending = 0;
    int m_per = 0, m_ctrl = 0, m_cnt = 0;
    int m_duty [2];
    int m_mode [2];
    int m_dir  [2];
    int m_tgt  [2];
    int m_left [2];
    bit m_raw  [2];
    bit m_irq = 0;

    int total = 0, bad = 0;
    bit chk_en = 0, win_en = 0;
    int hi_a = 0, hi_b = 0, ticks = 0, off_a = 0, off_b = 0;

    function automatic bit model_tick();
        return ((m_ctrl & 1) != 0) && (m_per != 0) && (m_cnt == m_per);
    endfunction

    function automatic logic [2:0] exp_pins(int c);
        logic [2:0] p;
        p = 3'b000;
        case (m_mode[c])
            DRV:     p = {m_raw[c], m_dir[c] != 0, m_dir[c] == 0};
            BRK:     p = 3'b111;
            default: p = 3'b000;
        endcase
        return p;
    endfunction

    always @(posedge ACLK) begin : model
        bit en, brk, wrap;
        int ds;
        if (ARESET) begin
            m_pend_per = 0; m_pend_da = 0; m_pend_db = 0; m_pend_ctrl = 0; m_pending = 0;
            m_per = 0; m_ctrl = 0; m_cnt = 0; m_irq = 0;
            for (int c = 0; c < 2; c++) begin
                m_duty[c] = 0; m_mode[c] = OFF; m_dir[c] = 0;
                m_tgt[c] = 0; m_left[c] = 0; m_raw[c] = 0;
            end
        end else begin
            en   = (m_ctrl & 1) != 0;
            brk  = (m_ctrl & 8) != 0;
            wrap = model_tick();
            for (int c = 0; c < 2; c++) begin
                ds = (m_ctrl >> (1 + c)) & 1;
                if (!en) begin
                    m_mode[c] = OFF;
                end else begin
                    case (m_mode[c])
                        OFF: if (brk) m_mode[c] = BRK;
                             else begin m_mode[c] = DRV; m_dir[c] = ds; end
                        DRV: if (brk) m_mode[c] = BRK;
                             else if (ds != m_dir[c]) begin
                                 m_mode[c] = DEADM; m_tgt[c] = ds; m_left[c] = DEADTIME;
                             end
                        DEADM: if (ds != m_tgt[c]) begin
                                   m_tgt[c] = ds; m_left[c] = DEADTIME;
                               end else begin
                                   m_left[c] = m_left[c] - 1;
                                   if (m_left[c] == 0) begin m_mode[c] = DRV; m_dir[c] = m_tgt[c]; end
                               end
                        default: if (!brk) begin
                                     m_mode[c] = DEADM; m_tgt[c] = ds; m_left[c] = DEADTIME;
                                 end
                    endcase
                end
                m_raw[c] = m_cnt < m_duty[c];
            end
            if (IRQ_ON) begin
                if (irq_ack) m_irq = 0;
                else if (wrap && ((m_ctrl & 16) != 0)) m_irq = 1;
            end
            m_cnt = (!en || m_per == 0 || wrap) ? 0 : m_cnt + 1;
            if (wrap || !en) begin
                m_per = m_pend_per; m_duty[0] = m_pend_da; m_duty[1] = m_pend_db;
                m_ctrl = m_pend_ctrl; m_pending = 0;
            end
            if (cfg_wr) begin
                m_pend_per = int'(cfg_period); m_pend_da = int'(cfg_duty_a);
                m_pend_db = int'(cfg_duty_b); m_pend_ctrl = int'(cfg_ctrl); m_pending = 1;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic wr(int per, int da, int db, int ctl);
        @(posedge ACLK); #1;
        cfg_period = CNT_W'(per); cfg_duty_a = CNT_W'(da);
        cfg_duty_b = CNT_W'(db); cfg_ctrl = 8'(ctl); cfg_wr = 1'b1;
        @(posedge ACLK); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic wait_applied(string name);
        for (int i = 0; i < 40; i++) begin
            if (!cfg_pending) break;
            @(posedge ACLK); #1;
        end
        check(name, cfg_pending, 0);
    endtask

    task automatic wait_tick(string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ACLK); #1;
            if (period_tick) begin seen = 1; break; end
        end
        check(name, seen, 1);
    endtask

    task automatic win_open();
        hi_a = 0; hi_b = 0; ticks = 0; off_a = 0; off_b = 0;
        win_en = 1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge ACLK);
                if (chk_en) begin
                    logic [8:0] act, exp;
                    act = {pwm_a, in1_a, in2_a, pwm_b, in1_b, in2_b, period_tick, cfg_pending, irq};
                    exp = {exp_pins(0), exp_pins(1), model_tick(), m_pending, m_irq};
                    total++;
                    if (act !== exp) begin
                        bad++;
                        $display("FAIL cycle_cmp t=%0t: got %b, expected %b", $time, act, exp);
                    end
                end
                if (win_en) begin
                    hi_a  += int'(pwm_a);
                    hi_b  += int'(pwm_b);
                    ticks += int'(period_tick);
                    off_a += int'(!in1_a && !in2_a);
                    off_b += int'(!in1_b && !in2_b);
                end
            end
        join_none

        // Power-on reset
        @(posedge ACLK); #1;
        chk_en = 1;
        cyc(3);
        check("rst_outputs", {pwm_a, pwm_b, in1_a, in2_a, in1_b, in2_b, period_tick, cfg_pending, irq}, 0);
        ARESET = 1'b0;

        // period=9 duty_a=3 ctrl=0x03: 3/10 high on A, B saturated at 100%
        wr(9, 3, 20, 8'h03);
        check("pend_set", cfg_pending, 1);
        cyc(15);
        win_open(); cyc(10); win_en = 0;
        check("duty3_hi_a", hi_a, 3);
        check("duty3_ticks", ticks, 1);
        check("duty20_hi_b", hi_b, 10);
        check("dir_a_pins", {in1_a, in2_a}, 2'b10);
        check("dir_b_pins", {in1_b, in2_b}, 2'b01);

        // duty_a 3->7 mid-period takes effect only from the next wrap
        wait_tick("tick_seen_1");
        cyc(3);
        wr(9, 7, 20, 8'h03);
        check("pend_mid", cfg_pending, 1);
        wait_applied("apply_duty7");
        win_open(); cyc(10); win_en = 0;
        check("duty7_hi_a", hi_a, 7);

        // dir_a 1->0: bridge A fully off for DEADTIME cycles
        win_open();
        wr(9, 7, 20, 8'h01);
        cyc(80); win_en = 0;
        check("dead_off_a", off_a, DEADTIME);
        check("dead_off_b", off_b, 0);
        check("rev_a_pins", {in1_a, in2_a}, 2'b01);

        // duty_b=0 -> constant low
        wr(9, 7, 0, 8'h01);
        wait_applied("apply_duty0");
        cyc(2);
        win_open(); cyc(10); win_en = 0;
        check("duty0_hi_b", hi_b, 0);

        // brake: all pins high on both channels
        wr(9, 7, 0, 8'h09);
        wait_applied("apply_brake");
        cyc(2);
        check("brake_b", {pwm_b, in1_b, in2_b}, 3'b111);
        check("brake_a", {pwm_a, in1_a, in2_a}, 3'b111);

        // brake release -> DEAD; dir_a flips 10 cycles into DEAD so A restarts its timer
        win_open();
        wr(9, 7, 0, 8'h01);
        wait_applied("apply_unbrake");
        wr(9, 7, 0, 8'h03);
        cyc(90); win_en = 0;
        check("unbrake_off_a", off_a, DEADTIME + 10);
        check("unbrake_off_b", off_b, DEADTIME);
        check("redrive_a", {in1_a, in2_a}, 2'b10);
        check("redrive_b", {in1_b, in2_b}, 2'b01);

        // reset mid-run with a write pending: everything clears, the write is lost
        wr(9, 3, 20, 8'h03);
        ARESET = 1'b1;
        cyc(1);
        check("rst_mid", {pwm_a, pwm_b, in1_a, in2_a, in1_b, in2_b, period_tick, cfg_pending, irq}, 0);
        cyc(3);
        ARESET = 1'b0;
        cyc(5);
        check("rst_lost", {pwm_a, pwm_b, in1_a, in2_a, in1_b, in2_b, period_tick, cfg_pending}, 0);

        // period interrupt: set at wrap, acked in the same cycle as the next wrap
        wr(9, 3, 20, 8'h13);
        wait_tick("tick_seen_2");
        cyc(1);
        check("irq_rise", irq, IRQ_ON);
        wait_tick("tick_seen_3");
        check("irq_hold", irq, IRQ_ON);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        check("irq_ack_wins", irq, 0);
        cyc(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
